uart_phy: RTL and testbench

//  8N1 serial transmitter/receiver that sits directly under the register block.
//  It consumes the host byte stream (in_*) and drives txd. It deserialises rxd

---
 rtl/uart_phy_pkg.sv | 30 +++
 rtl/uart_baudgen.sv | 32 +++
 rtl/uart_phy.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_phy.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_phy_pkg.sv
// Shared constants and state types for the 8N1 UART PHY.
// Bit timing is expressed in oversample ticks.
package uart_phy_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(SAMPLE_MID - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  function automatic int calc_div(int clk_hz, int baud);
    return clk_hz / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Free-running oversample tick divider shared by TX and RX.
// tick pulses for one clk each time the counter wraps.
module uart_baudgen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $fatal(1, "uart_baudgen: DIV must be >= 1");
  end

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_phy.sv
// 8N1 UART transmitter/receiver with a one-entry RX holding register.
// TX and RX run independently off one shared oversample tick.
module uart_phy
  import uart_phy_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       overrun,
  output logic       txd,
  input  logic       rxd
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  logic tick;

  uart_baudgen #(
    .DIV (DIV)
  ) u_baudgen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       txd_d;

  assign in_ready = (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (in_valid) begin
          tx_state_d = TX_START;
          tx_sh_d    = in_data;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == TICK_LAST) begin
            tx_state_d = TX_DATA;
            txd_d      = tx_sh_q[0];
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == TICK_LAST) begin
            if (tx_bit_q == 3'd7) begin
              tx_state_d = TX_STOP;
              txd_d      = 1'b1;
            end else begin
              tx_bit_d = tx_bit_q + 3'd1;
              tx_sh_d  = {1'b0, tx_sh_q[7:1]};
              txd_d    = tx_sh_q[1];
            end
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == TICK_LAST) begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd        <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd        <= txd_d;
    end
  end

  // rxd is asynchronous; only rxs feeds RX decisions
  logic rx_meta, rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       deliver;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    deliver    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rxs) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == TICK_MID) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rxs ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == TICK_LAST) begin
            rx_sh_d  = {rxs, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) begin
              rx_state_d = RX_STOP;
            end
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == TICK_LAST) begin
            deliver    = rxs;
            rx_state_d = rxs ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rxs) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  logic take;
  assign take = out_valid && out_ready;

  // a byte arriving in the same cycle as a drain replaces the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (deliver && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_data  <= rx_sh_q;
      end else if (take) begin
        out_valid <= 1'b0;
      end
      if (deliver && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (take) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy at DIV=1 (16 clk per bit).
// Line waveforms and the holding register are modelled at frame level.
module tb_uart_phy;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       overrun;
  logic       txd;
  logic       rxd;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;

  assign rxd = loopback ? txd : rxd_drv;

  always #5 clk = ~clk;

  uart_phy #(
    .CLK_HZ (1_843_200),
    .BAUD   (115_200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overrun   (overrun),
    .txd       (txd),
    .rxd       (rxd)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = '0;
  logic       exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_deliver(input logic [7:0] b);
    if (!exp_valid) begin
      exp_valid = 1'b1;
      exp_data  = b;
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_valid"}, out_valid, exp_valid);
    chk({tag, "_ovr"}, overrun, exp_ovr);
    if (exp_valid) chk({tag, "_data"}, out_data, exp_data);
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    if (exp_valid) begin
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
    end
    cyc(1);
    out_ready = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b);
    logic [9:0] frame;
    int k;
    int t;
    frame = {1'b1, b, 1'b0};
    t = 0;
    while (!in_ready && t < 400) begin
      cyc(1);
      t++;
    end
    chk("tx_ready_wait", (t < 400), 1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("tx_busy", in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(i == 0 ? 8 : 16);
      chk("tx_bit", txd, frame[i]);
    end
    k = 152;
    chk("tx_stop_busy", in_ready, 0);
    while (!in_ready && k < 170) begin
      cyc(1);
      k++;
    end
    chk("tx_done", (in_ready && k <= 162), 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame[i];
      cyc(16);
    end
  endtask

  logic [7:0] lb_q[$];
  logic [7:0] lb_got[$];
  logic [7:0] b;

  initial begin
    cyc(3);
    chk("rst_txd", txd, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    cyc(5);

    send_tx(8'hA5);
    for (int i = 0; i < 3; i++) send_tx(8'($urandom));

    send_rx(8'h3C, 1'b1);
    m_deliver(8'h3C);
    check_hold("rx3c");
    cyc(1000);
    check_hold("rx3c_hold");
    pulse_ready();
    cyc(2);
    check_hold("rx3c_drain");

    send_rx(8'h11, 1'b1);
    m_deliver(8'h11);
    send_rx(8'h22, 1'b1);
    m_deliver(8'h22);
    check_hold("ovr");
    pulse_ready();
    cyc(2);
    check_hold("ovr_clear");

    rxd_drv = 1'b0;
    cyc(4);
    rxd_drv = 1'b1;
    cyc(40);
    check_hold("glitch");
    send_rx(8'($urandom), 1'b0);
    cyc(40);
    rxd_drv = 1'b1;
    cyc(200);
    check_hold("frame_err");
    send_rx(8'h5A, 1'b1);
    m_deliver(8'h5A);
    check_hold("rx5a");
    pulse_ready();

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_rx(b, 1'b1);
      m_deliver(b);
      check_hold("rx_rand");
      if ($urandom_range(0, 1) == 1) begin
        pulse_ready();
        cyc(1);
        check_hold("rx_rand_drain");
      end
    end
    pulse_ready();

    send_rx(8'($urandom), 1'b1);
    send_rx(8'($urandom), 1'b1);
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc(50);
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_ovr", overrun, 1);
    rst = 1'b1;
    #1;
    chk("arst_txd", txd, 1);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_overrun", overrun, 0);
    cyc(2);
    rst = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    cyc(20);
    chk("post_rst_txd", txd, 1);
    check_hold("post_rst");

    lb_q = '{8'h00, 8'hFF, 8'h80, 8'($urandom), 8'($urandom)};
    loopback  = 1'b1;
    out_ready = 1'b1;
    cyc(2);
    fork
      begin
        int t;
        foreach (lb_q[i]) begin
          in_data  = lb_q[i];
          in_valid = 1'b1;
          t = 0;
          while (!in_ready && t < 400) begin
            cyc(1);
            t++;
          end
          chk("lb_tx_wait", (t < 400), 1);
          @(posedge clk);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (lb_got.size() < lb_q.size() && n < 1200) begin
          @(negedge clk);
          n++;
          if (out_valid) lb_got.push_back(out_data);
          if (overrun) chk("lb_overrun", overrun, 0);
        end
      end
    join
    chk("lb_count", lb_got.size(), lb_q.size());
    foreach (lb_got[i]) begin
      if (i < lb_q.size()) chk("lb_byte", lb_got[i], lb_q[i]);
    end
    chk("lb_overrun_end", overrun, 0);
    out_ready = 1'b0;
    loopback  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
